// File: rtl/shift_lane_sched_pkg.sv
// Shared types and sizing helpers for the serial lane scheduler and its arbiter.
package shift_lane_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    localparam int unsigned DefNreq  = 4;
    localparam int unsigned DefWidth = 8;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_lane_sched_if.sv
// Requester/lane bundle: parallel word handshakes in, one serial lane plus status out.
interface shift_lane_sched_if #(
    parameter int unsigned NREQ  = shift_lane_pkg::DefNreq,
    parameter int unsigned WIDTH = shift_lane_pkg::DefWidth
);
    localparam int unsigned IdW = shift_lane_pkg::clog2_min1(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  serial_out;
    logic                  shift_en;
    logic [IdW-1:0]        grant_id;
    logic                  busy;
    logic                  done;

    modport master (
        output req_valid, req_data,
        input  req_ready, serial_out, shift_en, grant_id, busy, done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, serial_out, shift_en, grant_id, busy, done
    );

endinterface

// File: rtl/shift_lane_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after ptr_i and wraps.
module rr_arbiter
    import shift_lane_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq,
    localparam int unsigned IdW = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdW-1:0]  idx_o,
    output logic            any_o
);

    int unsigned cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = (32'(ptr_i) + off) % NREQ;
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = IdW'(cand);
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_lane_sched.sv
// Round-robin scheduler serialising requester words LSB-first onto one lane.
// Optional macro PARITY_EN appends an even-parity bit to every frame.
module shift_lane_sched
    import shift_lane_pkg::*;
#(
    parameter int unsigned NREQ  = DefNreq,
    parameter int unsigned WIDTH = DefWidth
) (
    input logic               clk,
    input logic               rst,
    shift_lane_sched_if.slave bus
);

`ifdef PARITY_EN
    localparam int unsigned FrameLen = WIDTH + 1;
`else
    localparam int unsigned FrameLen = WIDTH;
`endif
    localparam int unsigned CntW = clog2_min1(FrameLen);
    localparam int unsigned IdW  = clog2_min1(NREQ);

    state_e              state_q, state_d;
    logic [FrameLen-1:0] shift_q, shift_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdW-1:0]      grant_q, grant_d;
    logic [IdW-1:0]      ptr_q, ptr_d;
    logic                done_q, done_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IdW-1:0]   arb_idx;
    logic             arb_any;
    logic [WIDTH-1:0] win_word;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req_i(bus.req_valid),
        .ptr_i(ptr_q),
        .gnt_o(arb_gnt),
        .idx_o(arb_idx),
        .any_o(arb_any)
    );

    assign win_word = bus.req_data[int'(arb_idx)*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Ready is the grant itself, so any request here is a handshake.
                if (arb_any) begin
`ifdef PARITY_EN
                    shift_d = {^win_word, win_word};
`else
                    shift_d = win_word;
`endif
                    grant_d = arb_idx;
                    ptr_d   = arb_idx;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                shift_d = {1'b0, shift_q[FrameLen-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(FrameLen - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            ptr_q   <= IdW'(NREQ - 1);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // rst gates ready directly so no accept is advertised while reset is held.
    assign bus.req_ready  = (state_q == StIdle && !rst) ? arb_gnt : '0;
    assign bus.serial_out = (state_q == StShift) ? shift_q[0] : 1'b0;
    assign bus.shift_en   = (state_q == StShift);
    assign bus.busy       = (state_q == StShift);
    assign bus.grant_id   = grant_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_shift_lane_sched.sv
// Directed self-checking bench for shift_lane_sched with NREQ=4, WIDTH=8.
module tb_shift_lane_sched;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    shift_lane_sched_if #(.NREQ(4), .WIDTH(8)) bus ();

    shift_lane_sched #(
        .NREQ(4),
        .WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        #8;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        total++; if (bus.serial_out !== 1'b0) begin bad++; $display("FAIL reset_serial: got %b want 0", bus.serial_out); end
        total++; if (bus.shift_en !== 1'b0) begin bad++; $display("FAIL reset_shift_en: got %b want 0", bus.shift_en); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
        #2;
        @(posedge clk);
        #2;
        bus.req_valid = '0;
        rst           = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'hA5;
        bus.req_data[2*8 +: 8] = w;
        bus.req_valid = 4'b0100;
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        total++; if (bus.grant_id !== 2'd2) begin bad++; $display("FAIL single_grant: got %0d want 2", bus.grant_id); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_busy: got %b want 0000", bus.req_ready); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            total++; if (bus.serial_out !== w[i] || bus.shift_en !== 1'b1) begin
                bad++; $display("FAIL single_bit%0d: got %b/%b want %b/1", i, bus.serial_out, bus.shift_en, w[i]);
            end
        end
        tick();
        total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_done: got done=%b busy=%b want 1/0", bus.done, bus.busy); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_withdraw();
        bus.req_valid = 4'b1000;
        #1;
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL withdraw_ready: got %b want 1000", bus.req_ready); end
        #1;
        bus.req_valid = '0;
        tick();
        total++; if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
            bad++; $display("FAIL withdraw_idle: got busy=%b ready=%b want 0/0000", bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] bit0;
        bit0 = 4'b0101;
        do_reset();
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            tick();
            total++; if (bus.grant_id !== 2'(f % 4) || bus.busy !== 1'b1 || bus.serial_out !== bit0[f % 4]) begin
                bad++; $display("FAIL rr_frame%0d: got id=%0d busy=%b bit=%b want %0d/1/%b",
                                f, bus.grant_id, bus.busy, bus.serial_out, f % 4, bit0[f % 4]);
            end
            repeat (7) tick();
            tick();
            total++; if (bus.done !== 1'b1 || bus.shift_en !== 1'b0 || bus.serial_out !== 1'b0) begin
                bad++; $display("FAIL rr_gap%0d: got done=%b en=%b ser=%b want 1/0/0",
                                f, bus.done, bus.shift_en, bus.serial_out);
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_sole();
        do_reset();
        bus.req_data[1*8 +: 8] = 8'h3C;
        bus.req_valid = 4'b0010;
        for (int f = 0; f < 3; f++) begin
            tick();
            total++; if (bus.grant_id !== 2'd1 || bus.busy !== 1'b1 || bus.serial_out !== 1'b0) begin
                bad++; $display("FAIL sole_start%0d: got id=%0d busy=%b bit=%b want 1/1/0",
                                f, bus.grant_id, bus.busy, bus.serial_out);
            end
            repeat (6) tick();
            tick();
            total++; if (bus.done !== 1'b0 || bus.shift_en !== 1'b1) begin
                bad++; $display("FAIL sole_last%0d: got done=%b en=%b want 0/1", f, bus.done, bus.shift_en);
            end
            tick();
            total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL sole_done%0d: got %b want 1", f, bus.done); end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_data[0 +: 8] = 8'hFF;
        bus.req_valid = 4'b0001;
        tick();
        tick();
        tick();
        total++; if (bus.serial_out !== 1'b1) begin bad++; $display("FAIL mid_pre: got %b want 1", bus.serial_out); end
        #4;
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        total++; if (bus.serial_out !== 1'b0 || bus.shift_en !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL mid_abort: got ser=%b en=%b busy=%b want 0/0/0", bus.serial_out, bus.shift_en, bus.busy);
        end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready: got %b want 0000", bus.req_ready); end
        tick();
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL mid_nodone: got done=%b busy=%b want 0/0", bus.done, bus.busy);
        end
        #1;
        rst = 1'b0;
        tick();
        total++; if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL mid_regrant: got id=%0d busy=%b want 0/1", bus.grant_id, bus.busy);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_frame_len();
        logic [8:0] expv;
        int         nbits;
        expv = 9'b1_0000_0111;
`ifdef PARITY_EN
        nbits = 9;
`else
        nbits = 8;
`endif
        do_reset();
        bus.req_data[3*8 +: 8] = 8'h07;
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) tick();
            total++; if (bus.serial_out !== expv[i] || bus.shift_en !== 1'b1) begin
                bad++; $display("FAIL len_bit%0d: got %b/%b want %b/1", i, bus.serial_out, bus.shift_en, expv[i]);
            end
        end
        tick();
        total++; if (bus.done !== 1'b1 || bus.shift_en !== 1'b0) begin
            bad++; $display("FAIL len_done: got done=%b en=%b want 1/0", bus.done, bus.shift_en);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_withdraw();
        test_round_robin();
        test_sole();
        test_reset_mid();
        test_frame_len();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
